// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: board-level system control block -- reset stretcher, button
// synchroniser/debouncer, free-running 64-bit tick counter and N-channel LED driver.
module pcileech_sysctl #(
    parameter int unsigned              PARAM_NUM_BTN       = 2,
    parameter int unsigned              PARAM_NUM_LED       = 3,
    parameter int unsigned              PARAM_RST_HOLD      = 64,
    parameter logic [PARAM_NUM_BTN-1:0] PARAM_BTN_RST_MASK  = PARAM_NUM_BTN'(2'b10),
    parameter int unsigned              PARAM_DEBOUNCE      = 1000000,
    parameter int unsigned              PARAM_STRETCH       = 4194304,
    parameter int unsigned              PARAM_HEARTBEAT_BIT = 26
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PARAM_NUM_BTN-1:0]     btn_raw,
    input  logic [PARAM_NUM_LED-1:0]     led_src,
    input  logic [2*PARAM_NUM_LED-1:0]   led_mode,
    input  logic                         led_invert,
    output logic [63:0]                  tickcount64,
    output logic                         rst_sys,
    output logic                         rst_ext_n,
    output logic [PARAM_NUM_BTN-1:0]     btn_db,
    output logic [PARAM_NUM_BTN-1:0]     btn_press,
    output logic [PARAM_NUM_LED-1:0]     led
);

    localparam int unsigned TICK_W = 64;
    localparam int unsigned DB_W   = (PARAM_DEBOUNCE > 1) ? $clog2(PARAM_DEBOUNCE) : 1;
    localparam int unsigned SC_W   = (PARAM_STRETCH  > 1) ? $clog2(PARAM_STRETCH)  : 1;
    localparam int unsigned HC_W   = (PARAM_RST_HOLD > 1) ? $clog2(PARAM_RST_HOLD) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(PARAM_DEBOUNCE - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(PARAM_STRETCH - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(PARAM_RST_HOLD - 1);
    localparam logic [5:0]      HB_IDX  = 6'(PARAM_HEARTBEAT_BIT);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Free-running tick counter
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [PARAM_NUM_BTN-1:0]           sync1_q;
    logic [PARAM_NUM_BTN-1:0]           sync2_q;
    logic [PARAM_NUM_BTN-1:0][DB_W-1:0] db_cnt_q;
    logic [PARAM_NUM_BTN-1:0][DB_W-1:0] db_cnt_d;
    logic [PARAM_NUM_BTN-1:0]           db_q;
    logic [PARAM_NUM_BTN-1:0]           db_d;
    logic [PARAM_NUM_BTN-1:0]           press_q;
    logic [PARAM_NUM_BTN-1:0]           press_d;

    // Any sample that agrees with the current debounced level restarts the count.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < int'(PARAM_NUM_BTN); i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_cnt_q <= '0;
            db_q     <= '0;
            press_q  <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            db_q     <= db_d;
            press_q  <= press_d;
        end
    end

    // ------------------------------------------------------------------
    // Reset stretcher FSM
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [HC_W-1:0]  hc_q;
    logic [HC_W-1:0]  hc_d;
    logic             rst_sys_q;
    logic             rst_ext_n_q;
    logic             btn_rst_c;

    always_comb begin
        btn_rst_c = |(db_q & PARAM_BTN_RST_MASK);
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        case (state_q)
            ST_HOLD: begin
                if (btn_rst_c) begin
                    hc_d = '0;
                end else if (hc_q == HC_LAST) begin
                    state_d = ST_RUN;
                    hc_d    = '0;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            ST_RUN: begin
                if (btn_rst_c) begin
                    state_d = ST_HOLD;
                    hc_d    = '0;
                end
            end
        endcase
    end

    // Outputs follow the next state so rst_sys drops on the same edge the FSM enters RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            hc_q        <= '0;
            rst_sys_q   <= 1'b1;
            rst_ext_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            rst_sys_q   <= (state_d == ST_HOLD);
            rst_ext_n_q <= (state_d != ST_HOLD);
        end
    end

    // ------------------------------------------------------------------
    // LED channels
    // ------------------------------------------------------------------
    logic [PARAM_NUM_LED-1:0][SC_W-1:0] sc_q;
    logic [PARAM_NUM_LED-1:0][SC_W-1:0] sc_d;
    logic [PARAM_NUM_LED-1:0]           led_stretch_c;
    logic [PARAM_NUM_LED-1:0]           led_raw_c;
    logic [PARAM_NUM_LED-1:0]           led_q;
    logic [PARAM_NUM_LED-1:0]           led_d;
    logic                               hb_c;

    // The stretch counter runs regardless of mode so switching to stretch mode shows recent activity.
    always_comb begin
        hb_c          = tick_q[HB_IDX];
        sc_d          = sc_q;
        led_stretch_c = '0;
        led_raw_c     = '0;
        led_d         = '0;
        for (int i = 0; i < int'(PARAM_NUM_LED); i++) begin
            if (led_src[i]) begin
                sc_d[i] = SC_LAST;
            end else if (sc_q[i] != '0) begin
                sc_d[i] = sc_q[i] - SC_W'(1);
            end
            led_stretch_c[i] = led_src[i] | (sc_q[i] != '0);
            case (led_mode[2*i +: 2])
                2'b00:   led_raw_c[i] = 1'b0;
                2'b01:   led_raw_c[i] = led_src[i];
                2'b10:   led_raw_c[i] = led_stretch_c[i];
                default: led_raw_c[i] = hb_c ^ led_src[i];
            endcase
            led_d[i] = led_raw_c[i] ^ led_invert;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q  <= '0;
            led_q <= '0;
        end else begin
            sc_q  <= sc_d;
            led_q <= led_d;
        end
    end

    assign tickcount64 = tick_q;
    assign rst_sys     = rst_sys_q;
    assign rst_ext_n   = rst_ext_n_q;
    assign btn_db      = db_q;
    assign btn_press   = press_q;
    assign led         = led_q;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// tb_pcileech_sysctl: directed self-checking bench for pcileech_sysctl with
// short hold/debounce/stretch parameters so every timing window is visible.
module tb_pcileech_sysctl;

    localparam int unsigned NB = 2;
    localparam int unsigned NL = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NB-1:0]   btn_raw;
    logic [NL-1:0]   led_src;
    logic [2*NL-1:0] led_mode;
    logic            led_invert;
    logic [63:0]     tickcount64;
    logic            rst_sys;
    logic            rst_ext_n;
    logic [NB-1:0]   btn_db;
    logic [NB-1:0]   btn_press;
    logic [NL-1:0]   led;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_tick;

    pcileech_sysctl #(
        .PARAM_NUM_BTN       (NB),
        .PARAM_NUM_LED       (NL),
        .PARAM_RST_HOLD      (8),
        .PARAM_BTN_RST_MASK  (2'b10),
        .PARAM_DEBOUNCE      (4),
        .PARAM_STRETCH       (5),
        .PARAM_HEARTBEAT_BIT (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .led_src     (led_src),
        .led_mode    (led_mode),
        .led_invert  (led_invert),
        .tickcount64 (tickcount64),
        .rst_sys     (rst_sys),
        .rst_ext_n   (rst_ext_n),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance to the next falling edge and check the tick against the bench model.
    task automatic step();
        logic r;
        r = rst;
        @(negedge clk);
        exp_tick = r ? 64'd0 : exp_tick + 64'd1;
        check("tick", tickcount64, exp_tick);
    endtask

    initial begin
        logic [63:0] t;
        logic        s;

        rst        = 1'b1;
        btn_raw    = '0;
        led_src    = '0;
        led_mode   = '0;
        led_invert = 1'b0;
        exp_tick   = '0;

        // Reset state
        repeat (3) step();
        check("rst_rst_sys",   64'(rst_sys),   64'd1);
        check("rst_ext_n",     64'(rst_ext_n), 64'd0);
        check("rst_btn_db",    64'(btn_db),    64'd0);
        check("rst_btn_press", 64'(btn_press), 64'd0);
        check("rst_led",       64'(led),       64'd0);

        // Reset release: 8-cycle stretch, tick starts at 0
        rst = 1'b0;
        check("tick0", tickcount64, 64'd0);
        for (int k = 0; k < 12; k++) begin
            check("hold_rst_sys",   64'(rst_sys),   64'(k < 8));
            check("hold_rst_ext_n", 64'(rst_ext_n), 64'(k >= 8));
            step();
        end

        // Bouncing unmasked button 0
        btn_raw[0] = 1'b1; step();
        btn_raw[0] = 1'b0; step();
        btn_raw[0] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            check("b0_db",      64'(btn_db[0]),    64'(j >= 6));
            check("b0_press",   64'(btn_press[0]), 64'(j == 6));
            check("b0_db1",     64'(btn_db[1]),    64'd0);
            check("b0_rst_sys", 64'(rst_sys),      64'd0);
        end

        // Masked button 1 held 20 cycles
        btn_raw[1] = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            check("b1_db",        64'(btn_db[1]),    64'(j >= 6));
            check("b1_press",     64'(btn_press[1]), 64'(j == 6));
            check("b1_rst_sys",   64'(rst_sys),      64'(j >= 7));
            check("b1_rst_ext_n", 64'(rst_ext_n),    64'(j < 7));
        end
        btn_raw[1] = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            check("b1r_db",      64'(btn_db[1]), 64'(j < 6));
            check("b1r_rst_sys", 64'(rst_sys),   64'(j < 14));
        end

        // Stretch mode on channel 0
        led_mode = 6'b00_00_10;
        step(); step();
        check("st_idle", 64'(led[0]), 64'd0);
        led_src[0] = 1'b1;
        step();
        check("st_p0", 64'(led[0]), 64'd1);
        led_src[0] = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step();
            check("st_single", 64'(led[0]), 64'(j <= 4));
        end
        for (int j = 0; j < 10; j++) begin
            led_src[0] = (j == 0 || j == 3);
            step();
            check("st_restart", 64'(led[0]),  64'(j <= 7));
            check("st_other",   64'(led[2:1]), 64'd0);
        end
        led_src[0] = 1'b0;

        // Heartbeat on channel 1, off on channel 2, then global invert
        led_mode = 6'b00_11_10;
        step();
        for (int j = 0; j < 20; j++) begin
            s = (j % 7 == 3);
            led_src[1] = s;
            step();
            t = exp_tick - 64'd1;
            check("hb_led1",  64'(led[1]), 64'(t[3] ^ s));
            check("hb_led2",  64'(led[2]), 64'd0);
        end
        led_src[1] = 1'b0;
        led_invert = 1'b1;
        step();
        for (int j = 0; j < 20; j++) begin
            s = (j % 5 == 1);
            led_src[1] = s;
            step();
            t = exp_tick - 64'd1;
            check("inv_led1", 64'(led[1]), 64'(t[3] ^ s ^ 1'b1));
            check("inv_led2", 64'(led[2]), 64'd1);
            check("inv_led0", 64'(led[0]), 64'd1);
        end
        led_src[1] = 1'b0;

        // Tick wrap with rst low
        force dut.tick_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.tick_q;
        exp_tick = 64'hFFFF_FFFF_FFFF_FFFE;
        check("tick_forced", tickcount64, exp_tick);
        step();
        step();
        check("tick_wrapped", tickcount64, 64'd0);
        step();

        // rst mid RUN with masked button pressed and tick near the top
        force dut.tick_q = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        release dut.tick_q;
        exp_tick   = 64'hFFFF_FFFF_FFFF_FFFC;
        btn_raw[1] = 1'b1;
        led_src    = 3'b111;
        repeat (3) step();
        check("pre_rst_tick",    tickcount64,   64'hFFFF_FFFF_FFFF_FFFF);
        check("pre_rst_rst_sys", 64'(rst_sys),  64'd0);
        check("pre_rst_db0",     64'(btn_db[0]), 64'd1);
        rst = 1'b1;
        step();
        check("mid_rst_rst_sys", 64'(rst_sys),   64'd1);
        check("mid_rst_ext_n",   64'(rst_ext_n), 64'd0);
        check("mid_rst_btn_db",  64'(btn_db),    64'd0);
        check("mid_rst_press",   64'(btn_press), 64'd0);
        check("mid_rst_led",     64'(led),       64'd0);
        rst     = 1'b0;
        btn_raw = '0;
        led_src = '0;
        step();
        check("post_rst_rst_sys", 64'(rst_sys), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
